// File: rtl/serial_mag_comp_ctrl_pkg.sv
// Shared definitions for the bit-serial magnitude comparator controller.
// Holds the FSM state encoding and the helper that sizes the bit-index
// and diff_idx fields from the operand width.
package serial_mag_comp_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of a field that can hold any bit index 0..width-1.
    // Never less than 1, so a zero-width vector cannot be declared.
    function automatic int idx_width(input int width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_mag_comp_ctrl_comp_1bit_nand.sv
// comp_1bit_nand: 1-bit magnitude comparator cell built only from 2-input
// NAND terms. Purely combinational.
//   a, b : input bits
//   l    : a < b  (a=0, b=1)
//   e    : a == b
//   g    : a > b  (a=1, b=0)
// Exactly one of l/e/g is high for any input pair.
module comp_1bit_nand (
    input  logic a,
    input  logic b,
    output logic l,
    output logic e,
    output logic g
);

    logic n_ab;
    logic n_gt;
    logic n_lt;
    logic n_eq;

    // n_ab = ~(a & b)
    assign n_ab = ~(a & b);
    // n_gt = ~(a & ~b), n_lt = ~(b & ~a): the shared n_ab term supplies the inversion
    assign n_gt = ~(a & n_ab);
    assign n_lt = ~(b & n_ab);
    // Equal when neither strict relation holds: e = n_gt & n_lt
    assign n_eq = ~(n_gt & n_lt);

    // NAND wired as an inverter for each output
    assign g = ~(n_gt & n_gt);
    assign l = ~(n_lt & n_lt);
    assign e = ~(n_eq & n_eq);

endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl: bit-serial unsigned magnitude comparator controller.
// Captures a and b on an accepted start and walks them MSB-first through a
// single comp_1bit_nand cell, one bit per clock, stopping at the first
// unequal bit or after the LSB. Trades latency (1..WIDTH cycles) for area
// against a full-width parallel comparator.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     compare request, sampled only in IDLE or DONE
//   a, b      operands, sampled on the accepting edge only
//   busy      high while comparing
//   done      one-cycle pulse, result valid
//   lt/eq/gt  registered result, held until the next accepted start
//   diff_idx  index of the deciding bit, 0 when equal
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, last result held
// CMP    | stepping bit idx through the cell, busy=1, lt/eq/gt=0
// DONE   | single cycle with done=1; start here chains a new compare
module serial_mag_comp_ctrl
    import serial_mag_comp_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [IDX_W-1:0] diff_idx
);

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [IDX_W-1:0] idx_d;
    logic             busy_d;
    logic             done_d;
    logic             lt_d;
    logic             eq_d;
    logic             gt_d;
    logic [IDX_W-1:0] diff_idx_d;

    logic             cell_l;
    logic             cell_e;
    logic             cell_g;
    logic             idx_zero;
    logic             accept;

    comp_1bit_nand u_cell (
        .a (a_q[idx_q]),
        .b (b_q[idx_q]),
        .l (cell_l),
        .e (cell_e),
        .g (cell_g)
    );

    assign idx_zero = (idx_q == '0);
    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lt       <= 1'b0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            diff_idx <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            busy     <= busy_d;
            done     <= done_d;
            lt       <= lt_d;
            eq       <= eq_d;
            gt       <= gt_d;
            diff_idx <= diff_idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = start ? S_CMP : S_IDLE;
            end
            S_CMP: begin
                // A decided bit or the LSB ends the walk; idx never wraps.
                if (!cell_e || idx_zero) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        lt_d       = lt;
        eq_d       = eq;
        gt_d       = gt;
        diff_idx_d = diff_idx;
        done_d     = 1'b0;
        busy_d     = (state_d == S_CMP);

        if (accept) begin
            a_d   = a;
            b_d   = b;
            idx_d = IDX_MSB;
            lt_d  = 1'b0;
            eq_d  = 1'b0;
            gt_d  = 1'b0;
        end else if (state_q == S_CMP) begin
            if (cell_g) begin
                gt_d       = 1'b1;
                diff_idx_d = idx_q;
                done_d     = 1'b1;
            end else if (cell_l) begin
                lt_d       = 1'b1;
                diff_idx_d = idx_q;
                done_d     = 1'b1;
            end else if (idx_zero) begin
                eq_d       = 1'b1;
                diff_idx_d = '0;
                done_d     = 1'b1;
            end else begin
                idx_d = idx_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
module tb_serial_mag_comp_ctrl;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [IDX_W-1:0] diff_idx;

    int n_vec = 0;
    int n_bad = 0;

    // result held by the DUT after the most recent completed compare: {lt,eq,gt}
    logic [2:0] last_res = 3'b000;
    int         last_di  = 0;

    serial_mag_comp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .lt       (lt),
        .eq       (eq),
        .gt       (gt),
        .diff_idx (diff_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned compare by arithmetic; the deciding bit is the
    // highest set bit of a^b; latency counts the bits walked from the MSB.
    task automatic ref_cmp(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                           output logic [2:0] res, output int di, output int k);
        int x;
        x = int'(ra ^ rb);
        if (ra < rb)      res = 3'b100;
        else if (ra > rb) res = 3'b001;
        else              res = 3'b010;
        if (x == 0) begin
            di = 0;
            k  = WIDTH;
        end else begin
            di = $clog2(x + 1) - 1;
            k  = WIDTH - di;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " res"}, {lt, eq, gt}, 0);
        check({tag, " diff_idx"}, diff_idx, 0);
    endtask

    // Issues start with ra/rb at the next negedge. If called right after a
    // previous run_cmp, that negedge falls in the DONE cycle (back-to-back).
    task automatic run_cmp(input string tag, input logic [WIDTH-1:0] ra,
                           input logic [WIDTH-1:0] rb, input bit disturb);
        logic [2:0] res;
        int di;
        int k;
        int cycles;
        ref_cmp(ra, rb, res, di, k);
        @(negedge clk);
        a = ra;
        b = rb;
        start = 1'b1;
        @(posedge clk);
        #1;
        cycles = 0;
        while (!done && cycles < WIDTH + 3) begin
            check({tag, " busy"}, busy, 1);
            check({tag, " cmp res"}, {lt, eq, gt}, 0);
            @(negedge clk);
            if (disturb) begin
                start = 1'($urandom_range(0, 1));
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, " latency"}, cycles, k);
        check({tag, " done"}, done, 1);
        check({tag, " busy at done"}, busy, 0);
        check({tag, " res"}, {lt, eq, gt}, res);
        check({tag, " diff_idx"}, diff_idx, di);
        last_res = res;
        last_di  = di;
    endtask

    // One cycle with start low: done must drop and the result must hold.
    task automatic idle_gap(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " done"}, done, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " hold res"}, {lt, eq, gt}, last_res);
        check({tag, " hold diff_idx"}, diff_idx, last_di);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        // reset held with start high
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'h12;
        b = 8'h34;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all_zero("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("post reset");

        // MSB decides
        run_cmp("msb", 8'h80, 8'h7F, 1'b0);
        idle_gap("msb gap");

        // equal operands
        run_cmp("equal", 8'hA5, 8'hA5, 1'b0);
        idle_gap("equal gap");

        // LSB decides
        run_cmp("lsb", 8'h10, 8'h11, 1'b0);
        idle_gap("lsb gap");

        // ignored start / operand changes, then back-to-back from DONE
        run_cmp("ignore", 8'h0F, 8'h0E, 1'b1);
        run_cmp("b2b", 8'h01, 8'h40, 1'b0);
        idle_gap("b2b gap");

        // reset in the 4th CMP cycle
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst busy before", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midrst idle");
        last_res = 3'b000;
        last_di  = 0;
        run_cmp("after rst", 8'h3C, 8'h3D, 1'b0);
        idle_gap("after rst gap");

        // random operands, biased toward long equal prefixes
        for (int i = 0; i < 60; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: rb = WIDTH'($urandom);
            endcase
            run_cmp("rand", ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                idle_gap("rand gap");
            end
        end
        idle_gap("final gap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
